// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
//
// Direct-mapped, write-through data cache with one data word per line, placed
// between the CPU memory stage and data_mem. Loads that hit are answered
// combinationally. A load miss stalls for exactly two cycles (the IDLE miss
// cycle plus one FILL cycle) while the line is fetched from data_mem. Stores
// always go straight through to data_mem in the same cycle, so data_mem
// always holds current data and the cache never needs a write-back path.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   AddrMode [2:0]      access size: DATA_ADDR_MODE_B, DATA_ADDR_MODE_BU,
//                       anything else is a word access
//   A, WD, WE, RE       CPU byte address, store data, store / load request
//   RD                  load data, valid when RE && !stall
//   stall               hold the pipeline (CPU keeps A/RE/AddrMode stable)
//   mem_A, mem_WD,
//   mem_WE, mem_AddrMode  request to data_mem
//   mem_RD              combinational read data from data_mem
//   hit_count,
//   miss_count          statistics counters
//
// Optional feature:
//   DCACHE_STATS_EN     when defined, hit_count / miss_count are saturating
//                       counters; otherwise no counter registers exist and
//                       both ports are tied to zero.
// -----------------------------------------------------------------------------
module data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            AddrMode,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic                  WE,
    input  logic                  RE,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    output logic                  mem_WE,
    output logic [2:0]            mem_AddrMode,
    input  logic [DATA_WIDTH-1:0] mem_RD,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    // Access-size encodings shared with data_mem (def.sv).
    localparam logic [2:0] DATA_ADDR_MODE_W  = 3'd0;
    localparam logic [2:0] DATA_ADDR_MODE_B  = 3'd1;
    localparam logic [2:0] DATA_ADDR_MODE_BU = 3'd2;

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state_q, state_d;

    logic [SETS-1:0]       valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [TAG_W-1:0]      tag_d  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS];
    logic [DATA_WIDTH-1:0] data_d [SETS];

    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_next;
    logic [TAG_W-1:0]      tag;
    logic                  is_byte;
    logic                  unaligned_word;
    logic [DATA_WIDTH-1:0] line_data;
    logic                  line_hit;
    logic                  load_hit;
    logic [7:0]            byte_val;
    logic [DATA_WIDTH-1:0] hit_rd;

    assign idx      = A[IDX_W+1:2];
    assign idx_next = idx + IDX_ONE;
    assign tag      = A[ADDR_WIDTH-1:IDX_W+2];

    assign is_byte        = (AddrMode == DATA_ADDR_MODE_B) || (AddrMode == DATA_ADDR_MODE_BU);
    // Unaligned word accesses bypass the cache entirely, so they can never hit.
    assign unaligned_word = !is_byte && (A[1:0] != 2'b00);

    assign line_data = data_q[idx];
    assign line_hit  = valid_q[idx] && (tag_q[idx] == tag) && !unaligned_word;
    assign load_hit  = (state_q == IDLE) && RE && !WE && line_hit;

    assign byte_val = line_data[{A[1:0], 3'b000} +: 8];

    always_comb begin
        hit_rd = line_data;
        if (AddrMode == DATA_ADDR_MODE_B) begin
            hit_rd = {{(DATA_WIDTH-8){byte_val[7]}}, byte_val};
        end else if (AddrMode == DATA_ADDR_MODE_BU) begin
            hit_rd = {{(DATA_WIDTH-8){1'b0}}, byte_val};
        end
    end

    // State register and array storage. Tag and data arrays need no reset
    // because every line is guarded by its valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    // Next-state and line-update logic.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (WE) begin
                    if (!is_byte && (A[1:0] == 2'b00)) begin
                        valid_d[idx] = 1'b1;
                        tag_d[idx]   = tag;
                        data_d[idx]  = WD;
                    end else begin
                        // Byte stores zero A+1..A+3 in data_mem and unaligned
                        // word stores span two words, so any store that is not
                        // an aligned word may touch the following line too.
                        valid_d[idx] = 1'b0;
                        if (A[1:0] != 2'b00) begin
                            valid_d[idx_next] = 1'b0;
                        end
                    end
                end else if (RE && !line_hit) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                state_d = IDLE;
                if (!unaligned_word) begin
                    valid_d[idx] = 1'b1;
                    tag_d[idx]   = tag;
                    data_d[idx]  = mem_RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic. During reset the bus is quiet and no data is returned.
    always_comb begin
        stall        = 1'b0;
        RD           = '0;
        mem_A        = A;
        mem_WD       = WD;
        mem_WE       = 1'b0;
        mem_AddrMode = AddrMode;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    mem_WE = WE;
                    if (!WE && RE) begin
                        if (line_hit) begin
                            RD = hit_rd;
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                FILL: begin
                    mem_AddrMode = DATA_ADDR_MODE_W;
                    if (unaligned_word) begin
                        // Uncached load completes directly from data_mem.
                        RD = mem_RD;
                    end else begin
                        mem_A = {A[ADDR_WIDTH-1:2], 2'b00};
                        stall = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Saturating counters; a miss is counted on every IDLE->FILL transition,
    // including uncached loads.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (load_hit && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if ((state_q == IDLE) && (state_d == FILL) && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    logic unused_stats;
    assign unused_stats = load_hit;
    assign hit_count    = 32'd0;
    assign miss_count   = 32'd0;
`endif

endmodule
